call_ctrl: RTL
==============

CALL_CTRL -- requirements
Module: call_ctrl

Interface
REQ-001 SHALL have parameter AW, default 10, PC/return-address width.
REQ-002 SHALL have parameter DEPTH, default 16, return-stack capacity in entries.
REQ-003 SHALL have parameter NIRQ, default 4, number of interrupt lines.
REQ-004 SHALL have parameter IRQ_BASE, default 10'h3F0, interrupt vector base address.
REQ-005 SHALL have ports: clk  in  1  clock, all state changes on rising edge; reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: call_req  in  1  decoded CALL; ret_req  in  1  decoded RET; reti_req  in  1  decoded RETI.
REQ-007 SHALL have ports: pc_cur  in  AW  current instruction address; call_target  in  AW  CALL destination; stack_top  in  AW  top entry of return stack.
REQ-008 SHALL have ports: irq  in  NIRQ  level interrupt requests; irq_en  in  1  global interrupt enable.
REQ-009 SHALL have ports: push  out  1; pop  out  1; push_data  out  AW  stack write data.
REQ-010 SHALL have ports: pc_sel  out  1  load next_pc; next_pc  out  AW; stall  out  1  suppress current instruction.
REQ-011 SHALL have ports: irq_ack  out  NIRQ  one-hot pulse; in_isr  out  1; depth  out  log2(DEPTH)+1  entries held; fault  out  1; fault_code  out  2.

Function
REQ-012 SHALL implement states IDLE, IRQ_PUSH, IRQ_JUMP, FAULT.
REQ-013 In IDLE, SHALL evaluate requests in this priority: interrupt > call > ret > reti. Call wins over simultaneous ret/reti.
REQ-014 Interrupt is pending when irq_en=1, in_isr=0, irq!=0 and depth<DEPTH. Lowest-index asserted line wins; its index SHALL be latched.
REQ-015 Pending interrupt in IDLE: stall=1, no push/pop; next state IRQ_PUSH. The instruction at pc_cur is not executed.
REQ-016 IRQ_PUSH: push=1, push_data=pc_cur, stall=1, depth+1; next state IRQ_JUMP.
REQ-017 IRQ_JUMP: pc_sel=1, next_pc=IRQ_BASE+{idx,2'b00}, stall=1, irq_ack[idx]=1 for this cycle only, in_isr<=1; next state IDLE.
REQ-018 CALL in IDLE with depth<DEPTH: single cycle. push=1, push_data=pc_cur+1 (mod 2^AW), pc_sel=1, next_pc=call_target, depth+1.
REQ-019 RET in IDLE with depth>0: single cycle. pop=1, pc_sel=1, next_pc=stack_top (value before pop), depth-1.
REQ-020 RETI in IDLE with in_isr=1 and depth>0: behaves as RET and also clears in_isr.
REQ-021 CALL at depth==DEPTH SHALL cause no push and enter FAULT with fault_code=2'b01 (overflow).
REQ-022 RET or RETI at depth==0 SHALL cause no pop and enter FAULT with fault_code=2'b10 (underflow).
REQ-023 RETI with in_isr=0 SHALL enter FAULT with fault_code=2'b11 (illegal RETI); this check precedes the underflow check.
REQ-024 FAULT: fault=1, stall=1, push=pop=pc_sel=0, irq_ack=0; held until reset, ignoring all inputs.
REQ-025 Interrupt with depth==DEPTH SHALL NOT be taken and SHALL NOT fault; the request stays pending in irq.
REQ-026 In IDLE with no request: all strobes 0, stall=0, pc_sel=0, next_pc=pc_cur+1.
REQ-027 push and pop SHALL never both be 1; depth SHALL always equal pushes minus pops since reset.
REQ-028 Requests arriving while in IRQ_PUSH or IRQ_JUMP SHALL be ignored; the CPU re-presents them after return.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, depth=0, in_isr=0, fault=0, fault_code=0, latched idx=0, from any state including IRQ_PUSH/IRQ_JUMP/FAULT.
REQ-030 While reset=1, push, pop, pc_sel, stall and irq_ack SHALL be 0.

Verification
REQ-031 CALL with pc_cur=0x010, call_target=0x200 -> same cycle push=1, push_data=0x011, next_pc=0x200; depth 0->1. Then RET with stack_top=0x011 -> pop=1, next_pc=0x011, depth 1->0.
REQ-032 irq=4'b0110, irq_en=1, pc_cur=0x055 -> sequence stall, push with 0x055, then next_pc=0x3F4 and irq_ack=4'b0010; in_isr=1. Then RETI -> pop, in_isr=0.
REQ-033 16 CALLs then a 17th CALL -> no push, fault=1, fault_code=01. Subsequent RET -> no pop. reset -> fault=0, depth=0.
REQ-034 RET at depth 0 -> fault_code=10. After reset, RETI with in_isr=0 -> fault_code=11.
REQ-035 CALL and irq asserted in the same cycle -> interrupt taken; call ignored. Depth=DEPTH with irq asserted -> no entry, no fault.
REQ-036 reset asserted during IRQ_PUSH -> next cycle IDLE with depth=0, in_isr=0, and no irq_ack pulse.

Source files
------------

// File: rtl/call_ctrl.sv
// call_ctrl: CALL/RET/RETI sequencing and interrupt entry for a CPU with an
// external return stack. Outputs are combinational from the registered state
// and the current decode. Faults are sticky until reset.
module call_ctrl #(
  parameter int              AW       = 10,
  parameter int              DEPTH    = 16,
  parameter int              NIRQ     = 4,
  parameter logic [AW-1:0]   IRQ_BASE = 10'h3F0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   call_req,
  input  logic                   ret_req,
  input  logic                   reti_req,
  input  logic [AW-1:0]          pc_cur,
  input  logic [AW-1:0]          call_target,
  input  logic [AW-1:0]          stack_top,
  input  logic [NIRQ-1:0]        irq,
  input  logic                   irq_en,
  output logic                   push,
  output logic                   pop,
  output logic [AW-1:0]          push_data,
  output logic                   pc_sel,
  output logic [AW-1:0]          next_pc,
  output logic                   stall,
  output logic [NIRQ-1:0]        irq_ack,
  output logic                   in_isr,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   fault,
  output logic [1:0]             fault_code
);
  localparam int DW = $clog2(DEPTH) + 1;
  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {IDLE, IRQ_PUSH, IRQ_JUMP, FAULT} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            in_isr_q, in_isr_d;
  logic [1:0]      code_q, code_d;
  logic [IW-1:0]   idx_q, idx_d, pend_idx;
  logic            irq_pend;
  logic            full, empty;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);

  // Lowest-index asserted interrupt line.
  always_comb begin
    pend_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (irq[i]) pend_idx = IW'(i);
  end

  // A full stack simply defers the interrupt; it never faults.
  assign irq_pend = irq_en && !in_isr_q && (|irq) && !full;

  // State register and architectural state, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      depth_q  <= '0;
      in_isr_q <= 1'b0;
      code_q   <= 2'b00;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      in_isr_q <= in_isr_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state and strobe decode; everything is quiet while reset is high.
  always_comb begin
    state_d   = state_q;
    in_isr_d  = in_isr_q;
    code_d    = code_q;
    idx_d     = idx_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    pc_sel    = 1'b0;
    next_pc   = pc_cur + AW'(1);
    stall     = 1'b0;
    irq_ack   = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (irq_pend) begin
            // Current instruction is dropped; it is re-fetched after the ISR.
            stall   = 1'b1;
            idx_d   = pend_idx;
            state_d = IRQ_PUSH;
          end else if (call_req) begin
            if (full) begin
              stall   = 1'b1;
              code_d  = 2'b01;
              state_d = FAULT;
            end else begin
              push      = 1'b1;
              push_data = pc_cur + AW'(1);
              pc_sel    = 1'b1;
              next_pc   = call_target;
            end
          end else if (ret_req || reti_req) begin
            // Illegal RETI is reported ahead of underflow.
            if (!ret_req && !in_isr_q) begin
              stall   = 1'b1;
              code_d  = 2'b11;
              state_d = FAULT;
            end else if (empty) begin
              stall   = 1'b1;
              code_d  = 2'b10;
              state_d = FAULT;
            end else begin
              pop     = 1'b1;
              pc_sel  = 1'b1;
              next_pc = stack_top;
              if (!ret_req) in_isr_d = 1'b0;
            end
          end
        end
        IRQ_PUSH: begin
          push      = 1'b1;
          push_data = pc_cur;
          stall     = 1'b1;
          state_d   = IRQ_JUMP;
        end
        IRQ_JUMP: begin
          pc_sel   = 1'b1;
          next_pc  = IRQ_BASE + (AW'(idx_q) << 2);
          stall    = 1'b1;
          irq_ack  = NIRQ'(1) << idx_q;
          in_isr_d = 1'b1;
          state_d  = IDLE;
        end
        default: begin
          stall = 1'b1;
        end
      endcase
    end
  end

  // Depth tracks pushes minus pops exactly.
  always_comb begin
    depth_d = depth_q;
    if (push)     depth_d = depth_q + DW'(1);
    else if (pop) depth_d = depth_q - DW'(1);
  end

  assign in_isr     = in_isr_q;
  assign depth      = depth_q;
  assign fault      = (state_q == FAULT);
  assign fault_code = code_q;
endmodule
